// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter and zero-fill sequencer
// in front of a single-port sync-write / comb-read RAM.
module ram_port_arbiter #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              clear_start,
    output logic              busy,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_sel,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_grant;
    logic              open;
    logic              grant0;
    logic              grant1;
    logic              clearing;

    // A pending clear request blocks grants in the same cycle.
    assign open     = (state == IDLE) && !reset && !clear_start;
    assign clearing = (state == CLEAR) && !reset;
    assign grant0   = open && req0_valid && (!req1_valid || last_grant);
    assign grant1   = open && req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ram_sel  = '0;
        ram_in   = '0;
        ram_load = 1'b0;
        unique case (1'b1)
            clearing: begin
                ram_sel  = cnt;
                ram_load = 1'b1;
            end
            grant0: begin
                ram_sel  = req0_addr;
                ram_in   = req0_we ? req0_wdata : '0;
                ram_load = req0_we;
            end
            grant1: begin
                ram_sel  = req1_addr;
                ram_in   = req1_we ? req1_wdata : '0;
                ram_load = req1_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            busy       <= CLEAR_ON_RESET;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= grant0 && !req0_we;
            rsp1_valid <= grant1 && !req1_we;
            if (grant0 && !req0_we)
                rsp0_data <= ram_out;
            if (grant1 && !req1_we)
                rsp1_data <= ram_out;
            if (grant0)
                last_grant <= 1'b0;
            else if (grant1)
                last_grant <= 1'b1;
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear_start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: cycle model of the arbitration rules
// plus directed scenarios with literal expectations.
module tb_ram_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_reset;
    logic          a_req0_valid, a_req0_we, a_req0_ready, a_rsp0_valid;
    logic [AW-1:0] a_req0_addr;
    logic [DW-1:0] a_req0_wdata, a_rsp0_data;
    logic          a_req1_valid, a_req1_we, a_req1_ready, a_rsp1_valid;
    logic [AW-1:0] a_req1_addr;
    logic [DW-1:0] a_req1_wdata, a_rsp1_data;
    logic          a_clear_start, a_busy, a_ram_load;
    logic [DW-1:0] a_ram_in, a_ram_out;
    logic [AW-1:0] a_ram_sel;

    logic          b_reset;
    logic          b_req0_valid, b_req0_we, b_req0_ready, b_rsp0_valid;
    logic [AW-1:0] b_req0_addr;
    logic [DW-1:0] b_req0_wdata, b_rsp0_data;
    logic          b_req1_valid, b_req1_we, b_req1_ready, b_rsp1_valid;
    logic [AW-1:0] b_req1_addr;
    logic [DW-1:0] b_req1_wdata, b_rsp1_data;
    logic          b_clear_start, b_busy, b_ram_load;
    logic [DW-1:0] b_ram_in, b_ram_out;
    logic [AW-1:0] b_ram_sel;

    logic [DW-1:0] ram_a [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];

    always @(posedge clk) if (a_ram_load) ram_a[a_ram_sel] <= a_ram_in;
    always @(posedge clk) if (b_ram_load) ram_b[b_ram_sel] <= b_ram_in;
    assign a_ram_out = ram_a[a_ram_sel];
    assign b_ram_out = ram_b[b_ram_sel];

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .reset(a_reset),
        .req0_valid(a_req0_valid), .req0_we(a_req0_we),
        .req0_addr(a_req0_addr), .req0_wdata(a_req0_wdata),
        .req0_ready(a_req0_ready), .rsp0_valid(a_rsp0_valid),
        .rsp0_data(a_rsp0_data),
        .req1_valid(a_req1_valid), .req1_we(a_req1_we),
        .req1_addr(a_req1_addr), .req1_wdata(a_req1_wdata),
        .req1_ready(a_req1_ready), .rsp1_valid(a_rsp1_valid),
        .rsp1_data(a_rsp1_data),
        .clear_start(a_clear_start), .busy(a_busy),
        .ram_in(a_ram_in), .ram_load(a_ram_load),
        .ram_sel(a_ram_sel), .ram_out(a_ram_out)
    );

    ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .reset(b_reset),
        .req0_valid(b_req0_valid), .req0_we(b_req0_we),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .req0_ready(b_req0_ready), .rsp0_valid(b_rsp0_valid),
        .rsp0_data(b_rsp0_data),
        .req1_valid(b_req1_valid), .req1_we(b_req1_we),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .req1_ready(b_req1_ready), .rsp1_valid(b_rsp1_valid),
        .rsp1_data(b_rsp1_data),
        .clear_start(b_clear_start), .busy(b_busy),
        .ram_in(b_ram_in), .ram_load(b_ram_load),
        .ram_sel(b_ram_sel), .ram_out(b_ram_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model of instance A: words left to clear, tie preference,
    // expected memory contents and pending read responses.
    logic [DW-1:0] exp_mem [DEPTH];
    bit            m_init = 1'b0;
    int            m_clear_left;
    int            m_prefer;
    bit            m_pend [2];
    logic [DW-1:0] m_data [2];
    int            m_w;
    logic          m_v [2];
    logic          m_we [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd [2];
    logic          e_load;
    logic [AW-1:0] e_sel;
    logic [DW-1:0] e_in;

    always @(negedge clk) begin
        if (!m_init) begin
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
            m_init = 1'b1;
        end
        if (a_reset) begin
            chk("rst_load", 32'(a_ram_load), 32'd0);
            chk("rst_ready0", 32'(a_req0_ready), 32'd0);
            chk("rst_ready1", 32'(a_req1_ready), 32'd0);
            chk("rst_rsp0_valid", 32'(a_rsp0_valid), 32'd0);
            chk("rst_rsp1_valid", 32'(a_rsp1_valid), 32'd0);
            chk("rst_busy", 32'(a_busy), 32'd1);
            m_clear_left = DEPTH;
            m_prefer     = 0;
            m_pend[0]    = 1'b0;
            m_pend[1]    = 1'b0;
            m_data[0]    = '0;
            m_data[1]    = '0;
        end else begin
            m_v[0] = a_req0_valid; m_we[0] = a_req0_we;
            m_addr[0] = a_req0_addr; m_wd[0] = a_req0_wdata;
            m_v[1] = a_req1_valid; m_we[1] = a_req1_we;
            m_addr[1] = a_req1_addr; m_wd[1] = a_req1_wdata;
            m_w = -1;
            e_load = 1'b0; e_sel = '0; e_in = '0;
            if (m_clear_left > 0) begin
                e_load = 1'b1;
                e_sel  = AW'(DEPTH - m_clear_left);
            end else if (!a_clear_start) begin
                if (m_v[0] && m_v[1]) m_w = m_prefer;
                else if (m_v[0]) m_w = 0;
                else if (m_v[1]) m_w = 1;
            end
            if (m_w >= 0) begin
                e_sel  = m_addr[m_w];
                e_in   = m_we[m_w] ? m_wd[m_w] : '0;
                e_load = m_we[m_w];
            end
            chk("busy", 32'(a_busy), 32'(m_clear_left > 0));
            chk("ready0", 32'(a_req0_ready), 32'(m_w == 0));
            chk("ready1", 32'(a_req1_ready), 32'(m_w == 1));
            chk("ram_load", 32'(a_ram_load), 32'(e_load));
            chk("ram_sel", 32'(a_ram_sel), 32'(e_sel));
            chk("ram_in", 32'(a_ram_in), 32'(e_in));
            chk("rsp0_valid", 32'(a_rsp0_valid), 32'(m_pend[0]));
            chk("rsp1_valid", 32'(a_rsp1_valid), 32'(m_pend[1]));
            chk("rsp0_data", 32'(a_rsp0_data), 32'(m_data[0]));
            chk("rsp1_data", 32'(a_rsp1_data), 32'(m_data[1]));
            m_pend[0] = 1'b0;
            m_pend[1] = 1'b0;
            if (m_clear_left > 0) begin
                exp_mem[e_sel] = '0;
                m_clear_left--;
            end else if (a_clear_start) begin
                m_clear_left = DEPTH;
            end else if (m_w >= 0) begin
                m_prefer = 1 - m_w;
                if (m_we[m_w]) begin
                    exp_mem[m_addr[m_w]] = m_wd[m_w];
                end else begin
                    m_data[m_w] = exp_mem[m_addr[m_w]];
                    m_pend[m_w] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int port, input int bound,
                              output int cyc);
        logic ok;
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < bound) begin
            @(negedge clk);
            cyc++;
            ok = (port == 0) ? a_req0_ready : a_req1_ready;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready%0d: no grant within %0d cycles",
                     port, bound);
        end
    endtask

    task automatic xfer(input int port, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int c;
        if (port == 0) begin
            a_req0_valid = 1'b1; a_req0_we = we;
            a_req0_addr = addr; a_req0_wdata = wd;
        end else begin
            a_req1_valid = 1'b1; a_req1_we = we;
            a_req1_addr = addr; a_req1_wdata = wd;
        end
        wait_ready(port, 10, c);
        step();
        if (port == 0) a_req0_valid = 1'b0;
        else a_req1_valid = 1'b0;
    endtask

    int   c, k0, k1, n0, n1;
    logic g0, g1;

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_req0_valid = 0; a_req0_we = 0; a_req0_addr = '0; a_req0_wdata = '0;
        a_req1_valid = 0; a_req1_we = 0; a_req1_addr = '0; a_req1_wdata = '0;
        b_req0_valid = 0; b_req0_we = 0; b_req0_addr = '0; b_req0_wdata = '0;
        b_req1_valid = 0; b_req1_we = 0; b_req1_addr = '0; b_req1_wdata = '0;
        a_clear_start = 0; b_clear_start = 0;

        // Power-up clear with port 0 waiting throughout
        a_req0_valid = 1'b1;
        repeat (3) step();
        a_reset = 1'b0;
        wait_ready(0, 5000, c);
        chk("first_grant_cycle", c, 32'd4097);
        step();
        a_req0_addr = 12'd2047;
        @(negedge clk);
        chk("rd_0_valid", 32'(a_rsp0_valid), 32'd1);
        chk("rd_0_data", 32'(a_rsp0_data), 32'h0000);
        chk("b2b_ready", 32'(a_req0_ready), 32'd1);
        step();
        a_req0_addr = 12'd4095;
        @(negedge clk);
        chk("rd_2047_data", 32'(a_rsp0_data), 32'h0000);
        step();
        a_req0_valid = 1'b0;
        @(negedge clk);
        chk("rd_4095_valid", 32'(a_rsp0_valid), 32'd1);
        chk("rd_4095_data", 32'(a_rsp0_data), 32'h0000);

        // Read-after-write on port 0
        xfer(0, 1'b1, 12'h123, 16'hBEEF);
        xfer(0, 1'b0, 12'h123, 16'h0000);
        @(negedge clk);
        chk("raw_valid", 32'(a_rsp0_valid), 32'd1);
        chk("raw_data", 32'(a_rsp0_data), 32'hBEEF);
        chk("raw_rsp1_quiet", 32'(a_rsp1_valid), 32'd0);
        step();
        @(negedge clk);
        chk("raw_pulse_end", 32'(a_rsp0_valid), 32'd0);
        chk("raw_data_hold", 32'(a_rsp0_data), 32'hBEEF);

        // Both ports valid: strict alternation
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b1, AW'(12'h400 + i), DW'(16'h2000 + i));
            xfer(1, 1'b1, AW'(12'h300 + i), DW'(16'h1000 + i));
        end
        k0 = 0; k1 = 0; n0 = 0; n1 = 0;
        a_req0_valid = 1'b1; a_req0_we = 1'b0; a_req0_addr = 12'h400;
        a_req1_valid = 1'b1; a_req1_we = 1'b0; a_req1_addr = 12'h300;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_rsp0_valid) begin
                chk("alt_rsp0_data", 32'(a_rsp0_data), 32'h2000 + n0);
                n0++;
            end
            if (a_rsp1_valid) begin
                chk("alt_rsp1_data", 32'(a_rsp1_data), 32'h1000 + n1);
                n1++;
            end
            chk("alt_grant", 32'({a_req1_ready, a_req0_ready}),
                (i % 2 == 1) ? 32'd2 : 32'd1);
            g0 = a_req0_ready;
            g1 = a_req1_ready;
            step();
            if (g0) begin k0++; a_req0_addr = AW'(12'h400 + k0); end
            if (g1) begin k1++; a_req1_addr = AW'(12'h300 + k1); end
        end
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        @(negedge clk);
        if (a_rsp0_valid) n0++;
        if (a_rsp1_valid) begin
            chk("alt_rsp1_last", 32'(a_rsp1_data), 32'h1000 + n1);
            n1++;
        end
        chk("alt_count0", n0, 32'd4);
        chk("alt_count1", n1, 32'd4);

        // Clear command beats a simultaneous request
        xfer(0, 1'b1, 12'h0FF, 16'h7777);
        a_clear_start = 1'b1;
        a_req1_valid = 1'b1; a_req1_we = 1'b0; a_req1_addr = 12'h0FF;
        @(negedge clk);
        chk("clr_no_grant1", 32'(a_req1_ready), 32'd0);
        chk("clr_no_load", 32'(a_ram_load), 32'd0);
        chk("clr_busy_low", 32'(a_busy), 32'd0);
        step();
        a_clear_start = 1'b0;
        @(negedge clk);
        chk("clr_busy_rise", 32'(a_busy), 32'd1);
        wait_ready(1, 5000, c);
        chk("clr_wait", c, 32'd4096);
        step();
        a_req1_valid = 1'b0;
        @(negedge clk);
        chk("clr_rd_valid", 32'(a_rsp1_valid), 32'd1);
        chk("clr_rd_data", 32'(a_rsp1_data), 32'h0000);

        // Reset in the middle of a clear
        a_clear_start = 1'b1;
        step();
        a_clear_start = 1'b0;
        repeat (1000) step();
        @(negedge clk);
        chk("mid_sel", 32'(a_ram_sel), 32'd1000);
        chk("mid_load", 32'(a_ram_load), 32'd1);
        #1 a_reset = 1'b1;
        #1 chk("mid_rst_load", 32'(a_ram_load), 32'd0);
        step();
        step();
        a_reset = 1'b0;
        c = 0;
        while (c < 5000) begin
            @(negedge clk);
            if (!a_busy) break;
            c++;
            if (c == 1) chk("reclear_sel0", 32'(a_ram_sel), 32'd0);
        end
        chk("reclear_len", c, 32'd4096);

        // No clear on reset: contents survive a reset
        b_req1_valid = 1'b1; b_req1_we = 1'b1;
        b_req1_addr = 12'h0AB; b_req1_wdata = 16'h5A5A;
        step();
        b_reset = 1'b0;
        @(negedge clk);
        chk("b_busy", 32'(b_busy), 32'd0);
        chk("b_wr_ready", 32'(b_req1_ready), 32'd1);
        step();
        b_req1_we = 1'b0;
        b_reset = 1'b1;
        @(negedge clk);
        chk("b_rst_busy", 32'(b_busy), 32'd0);
        chk("b_rst_ready", 32'(b_req1_ready), 32'd0);
        chk("b_rst_load", 32'(b_ram_load), 32'd0);
        step();
        b_reset = 1'b0;
        @(negedge clk);
        chk("b_idle_ready", 32'(b_req1_ready), 32'd1);
        chk("b_idle_busy", 32'(b_busy), 32'd0);
        step();
        b_req1_valid = 1'b0;
        @(negedge clk);
        chk("b_rd_valid", 32'(b_rsp1_valid), 32'd1);
        chk("b_rd_data", 32'(b_rsp1_data), 32'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
